// File: rtl/shift_cmd_pkg.sv
// Shared types and default sizing for the shift command sequencer.
package shift_cmd_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_LEN_W = 4;

    // Command opcode; the encoding is the downstream shift register's ctrl.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SHR  = 2'd1,
        SHL  = 2'd2,
        LOAD = 2'd3
    } op_t;

    // Sequencer control state.
    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_cmd_bitsel.sv
// Maps an opcode, a command word and a beat index to one beat's ctrl/data.
module shift_cmd_bitsel
    import shift_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] data,
    input  logic [IDX_W-1:0] idx,
    output logic [1:0]       beat_ctrl_c,
    output logic [WIDTH-1:0] beat_data_c
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

    // SHR feeds the MSB serial input LSB-first; SHL feeds the LSB serial input MSB-first.
    always_comb begin
        beat_ctrl_c = 2'(op);
        beat_data_c = '0;
        case (op)
            SHR:     beat_data_c[WIDTH-1] = data[idx];
            SHL:     beat_data_c[0]       = data[TOP_IDX - idx];
            LOAD:    beat_data_c          = data;
            default: beat_data_c          = '0;
        endcase
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Expands accepted commands into per-cycle ctrl/data beats for a shift register.
module shift_cmd_sequencer
    import shift_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [1:0]       sr_ctrl,
    output logic [WIDTH-1:0] sr_data,
    output logic             busy,
    output logic             done
);

    localparam int unsigned       IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  TOP_IDX = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    op_t                sel_op;
    logic [WIDTH-1:0]   sel_data;
    logic [IDX_W-1:0]   sel_idx;
    logic               beat_en;
    logic               last_beat;
    logic               accept;
    logic [1:0]         beat_ctrl_c;
    logic [WIDTH-1:0]   beat_data_c;

    // A new command may land on the final beat so back-to-back commands leave no gap.
    assign last_beat = (state_q == RUN) && (cnt_q == last_q);
    assign cmd_ready = (state_q == IDLE) || last_beat;
    assign accept    = cmd_valid && cmd_ready;

    shift_cmd_bitsel #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bitsel (
        .op          (sel_op),
        .data        (sel_data),
        .idx         (sel_idx),
        .beat_ctrl_c (beat_ctrl_c),
        .beat_data_c (beat_data_c)
    );

    // Next state, command latch and selection of the beat to register next.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        idx_d    = idx_q;
        sel_op   = op_q;
        sel_data = data_q;
        sel_idx  = idx_q;
        beat_en  = 1'b0;

        case (state_q)
            INIT: state_d = IDLE;
            IDLE, RUN: begin
                if (accept) begin
                    op_d     = op_t'(cmd_op);
                    data_d   = cmd_data;
                    last_d   = (op_t'(cmd_op) == LOAD) ? '0 : cmd_len;
                    cnt_d    = '0;
                    idx_d    = '0;
                    sel_op   = op_t'(cmd_op);
                    sel_data = cmd_data;
                    sel_idx  = '0;
                    beat_en  = 1'b1;
                    state_d  = RUN;
                end else if ((state_q == RUN) && !last_beat) begin
                    cnt_d    = cnt_q + LEN_W'(1);
                    idx_d    = (idx_q == TOP_IDX) ? '0 : idx_q + IDX_W'(1);
                    sel_idx  = idx_d;
                    beat_en  = 1'b1;
                end else if (state_q == RUN) begin
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, beat counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= HOLD;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            sr_ctrl <= 2'b00;
            sr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            sr_ctrl <= beat_en ? beat_ctrl_c : 2'b00;
            sr_data <= beat_en ? beat_data_c : '0;
            busy    <= beat_en;
            done    <= last_beat;
        end
    end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench for shift_cmd_sequencer with a downstream shift register model.
module tb_shift_cmd_sequencer;

    localparam int unsigned W = 8;
    localparam int unsigned L = 4;

    typedef struct {
        logic [1:0]   ctrl;
        logic [W-1:0] data;
        bit           last;
    } beat_t;

    logic         clk;
    logic         resetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [L-1:0] cmd_len;
    logic [1:0]   sr_ctrl;
    logic [W-1:0] sr_data;
    logic         busy;
    logic         done;

    beat_t        exp_q[$];
    beat_t        mon_b;
    bit           prev_last    = 1'b0;
    bit           init_pending = 1'b0;
    int           n_cmp        = 0;
    int           n_bad        = 0;
    int           done_count   = 0;
    logic [W-1:0] ds           = '0;

    shift_cmd_sequencer #(
        .WIDTH (W),
        .LEN_W (L)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .sr_ctrl   (sr_ctrl),
        .sr_data   (sr_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the list of beats a command should produce.
    task automatic push_model(input logic [1:0] op, input logic [W-1:0] d, input logic [L-1:0] len);
        int n;
        n = (op == 2'd3) ? 1 : int'(len) + 1;
        for (int k = 0; k < n; k++) begin
            beat_t b;
            int    i;
            i      = k % W;
            b.ctrl = op;
            b.data = '0;
            b.last = (k == n - 1);
            case (op)
                2'd1:    b.data[W-1] = d[i];
                2'd2:    b.data[0]   = d[W-1-i];
                2'd3:    b.data      = d;
                default: b.data      = '0;
            endcase
            exp_q.push_back(b);
        end
    endtask

    // Downstream shift register driven by the sequencer outputs.
    always @(posedge clk) begin
        case (sr_ctrl)
            2'd1:    ds <= {sr_data[W-1], ds[W-1:1]};
            2'd2:    ds <= {ds[W-2:0], sr_data[0]};
            2'd3:    ds <= sr_data;
            default: ds <= ds;
        endcase
    end

    // Monitor: compare what the DUT shows each cycle against the scoreboard.
    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_ctrl", 32'(sr_ctrl), 0);
            check("rst_data", 32'(sr_data), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_ready", 32'(cmd_ready), 0);
            prev_last = 1'b0;
        end else if (init_pending) begin
            check("init_ready", 32'(cmd_ready), 0);
            check("init_busy", 32'(busy), 0);
            check("init_done", 32'(done), 0);
            init_pending = 1'b0;
            prev_last    = 1'b0;
        end else if (exp_q.size() == 0) begin
            check("idle_busy", 32'(busy), 0);
            check("idle_ctrl", 32'(sr_ctrl), 0);
            check("idle_data", 32'(sr_data), 0);
            check("idle_ready", 32'(cmd_ready), 1);
            check("done", 32'(done), 32'(prev_last));
            prev_last = 1'b0;
        end else begin
            mon_b = exp_q.pop_front();
            check("beat_busy", 32'(busy), 1);
            check("beat_ctrl", 32'(sr_ctrl), 32'(mon_b.ctrl));
            check("beat_data", 32'(sr_data), 32'(mon_b.data));
            check("beat_ready", 32'(cmd_ready), 32'(mon_b.last));
            check("done", 32'(done), 32'(prev_last));
            prev_last = mon_b.last;
        end
        if (resetn && done) done_count++;
    end

    // Present a command; fields stay scrambled until the cycle it can be accepted.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [L-1:0] len);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom);
        cmd_data  = W'($urandom);
        cmd_len   = L'($urandom);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            #1;
            if (cmd_ready) begin
                cmd_op   = op;
                cmd_data = d;
                cmd_len  = len;
                push_model(op, d, len);
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end else begin
                cmd_op   = 2'($urandom);
                cmd_data = W'($urandom);
                cmd_len  = L'($urandom);
            end
        end
        if (!ok) begin
            check("send_timeout", 0, 1);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = W'($urandom);
        cmd_len   = L'($urandom);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until every expected beat has been shown and consumed downstream.
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_len   = '0;
        repeat (3) @(posedge clk);
        #2;
        resetn       = 1'b1;
        init_pending = 1'b1;
        @(posedge clk);
        #1;

        // SHR 0xB4, 8 beats
        d0 = done_count;
        send(2'd1, 8'hB4, 4'd7);
        idle(0);
        wait_idle();
        check("shr_b4_downstream", 32'(ds), 32'h0000_00B4);
        check("shr_b4_done_count", 32'(done_count - d0), 1);

        // SHL 0x3C, 8 beats
        d0 = done_count;
        send(2'd2, 8'h3C, 4'd7);
        idle(0);
        wait_idle();
        check("shl_3c_downstream", 32'(ds), 32'h0000_003C);
        check("shl_3c_done_count", 32'(done_count - d0), 1);

        // LOAD then HOLD back to back
        d0 = done_count;
        send(2'd3, 8'hA5, 4'hF);
        send(2'd0, 8'hFF, 4'd2);
        idle(0);
        wait_idle();
        check("load_hold_downstream", 32'(ds), 32'h0000_00A5);
        check("load_hold_done_count", 32'(done_count - d0), 2);

        // Single beat, then 16-beat wrap-around
        d0 = done_count;
        send(2'd1, 8'h01, 4'd0);
        send(2'd1, 8'h01, 4'd15);
        idle(0);
        wait_idle();
        check("shr_wrap_downstream", 32'(ds), 32'h0000_0001);
        check("shr_wrap_done_count", 32'(done_count - d0), 2);

        // Long command with the next one held valid (scrambled) while busy
        d0 = done_count;
        send(2'd1, 8'hC3, 4'd9);
        send(2'd3, 8'h5A, 4'd0);
        idle(0);
        wait_idle();
        check("busy_hold_downstream", 32'(ds), 32'h0000_005A);
        check("busy_hold_done_count", 32'(done_count - d0), 2);

        // Reset during beat 3 of an 8-beat SHR
        d0 = done_count;
        send(2'd1, 8'hFF, 4'd7);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("abort_ctrl", 32'(sr_ctrl), 0);
        check("abort_data", 32'(sr_data), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_ready", 32'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        resetn       = 1'b1;
        init_pending = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        check("abort_no_done", 32'(done_count - d0), 0);

        // Randomized commands with random gaps
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? L'($urandom) : L'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command-driven stimulus stage that sits directly upstream of `shift_register` and drives its `ctrl`/`data` inputs. It accepts one command per valid/ready handshake (hold, right-shift stream, left-shift stream, parallel load) and expands it into a run of per-cycle `ctrl`/`data` beats. Shift commands stream the bits of a command word so that WIDTH beats reproduce that word in the downstream register. `done` marks completion for the sequencing layer above.

## Interface
- `WIDTH`, 8, datapath width; matches the downstream shift register.
- `LEN_W`, 4, width of the beat-count field.
- `clk`  in  1  single clock; every flop is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on an edge when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  0 HOLD, 1 SHR, 2 SHL, 3 LOAD; same encoding as downstream `ctrl`.
- `cmd_data`  in  WIDTH  word to stream or load.
- `cmd_len`  in  LEN_W  beat count minus 1 for HOLD/SHR/SHL; ignored for LOAD.
- `sr_ctrl`  out  2  to downstream `ctrl`.
- `sr_data`  out  WIDTH  to downstream `data`.
- `busy`  out  1  a command is executing.
- `done`  out  1  one-cycle pulse after the last beat of each command.

## Operation
- States: INIT, IDLE, RUN. While `resetn` is low: INIT. First edge after release: INIT→IDLE.
- Reset values: `cmd_ready`=0, `sr_ctrl`=0, `sr_data`=0, `busy`=0, `done`=0. Internal beat counter, op, and data registers are all 0.
- `cmd_ready` = (state==IDLE) | (state==RUN & last beat). It is combinational from state and counter, and is 0 in INIT.
- On acceptance, latch op, data, and N. N = 1 for LOAD, otherwise `cmd_len`+1, giving 1..2^LEN_W. Enter RUN with beat index k=0.
- Beat k outputs, registered:
  - HOLD: `sr_ctrl`=0, `sr_data`=0.
  - SHR: `sr_ctrl`=1, `sr_data`[WIDTH-1] = data[k mod WIDTH], all other bits 0. Feeds the LSB first into the MSB serial input.
  - SHL: `sr_ctrl`=2, `sr_data`[0] = data[WIDTH-1-(k mod WIDTH)], all other bits 0. Feeds the MSB first into the LSB serial input.
  - LOAD: `sr_ctrl`=3, `sr_data`=data.
- Beat index k is held modulo WIDTH. For N > WIDTH the bit pattern wraps around and repeats.
- After beat N-1:
  - If a new command is accepted on that edge, its beat 0 follows with no gap, and `busy` stays 1.
  - Otherwise go to IDLE. `sr_ctrl` and `sr_data` return to 0 (downstream holds its value) and `busy` drops to 0.
- `done` is 1 in the cycle after each command's final beat, including back-to-back commands.
- `cmd_valid` is ignored when `cmd_ready`=0. Command fields are sampled only at acceptance.
- Asserting `resetn` mid-run aborts the command immediately: outputs go to their reset values and no `done` is issued.

## Timing
- Latency: command accepted at edge E → beat 0 on the outputs from E to E+1. Beat k is valid for the cycle starting at E+k.
- The downstream register samples on the same clock. Beat k therefore takes effect at edge E+k+1.
- Throughput: one beat per cycle. Back-to-back commands achieve 100% beat occupancy.
- `busy` is high during every beat cycle.

## Structure
- Package `shift_cmd_pkg` holds:
  - `op_t` enum: HOLD=0, SHR=1, SHL=2, LOAD=3.
  - `state_t` enum: INIT, IDLE, RUN.
  - The default WIDTH/LEN_W constants.
- Sub-module `shift_cmd_bitsel` is combinational. Given op, data, and k, it produces the beat's `sr_ctrl`/`sr_data`. The top contains the FSM, counter, and output registers.

## Test plan
- After reset release, send SHR with data=0xB4, len=7 → `sr_data`[7] over beats 0..7 is 0,0,1,0,1,1,0,1; `sr_ctrl`=1 for 8 cycles; downstream reads 0xB4; `done` pulses once.
- Send SHL with data=0x3C, len=7 → `sr_data`[0] over beats 0..7 is 0,0,1,1,1,1,0,0; downstream reads 0x3C.
- Send LOAD 0xA5, held valid, followed by HOLD len=2 → one beat with `sr_ctrl`=3, `sr_data`=0xA5, then 3 beats with `sr_ctrl`=0 and no gap; `done` pulses twice; downstream stays 0xA5.
- Send SHR with data=0x01, len=0 → exactly one beat with `sr_data`=0x80. Then SHR with data=0x01, len=15 → beats 0 and 8 carry 1 (wrap-around), and the remaining 14 beats carry 0.
- Assert `resetn` low at beat 3 of an 8-beat SHR → all outputs go to 0 immediately and no `done` is issued. `cmd_ready` is 0 for the first cycle after release, then 1.
- Hold `cmd_valid` high while busy (not in the last beat) → no acceptance occurs and the fields of the next command are sampled only at the ready edge.
